branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Fetch-side partner of the execute-stage branch evaluator. Predicts direction for branch instructions at fetch using a direct-mapped table of 2-bit saturating counters. Accepts resolved outcomes from execute, trains the table, and on a misprediction issues a registered PC redirect plus a multi-cycle pipeline flush. Sits between the fetch stage and the execute-stage `taken` output.

## Interface
- `BITWIDTH`, 32: PC and target width.
- `ENTRIES`, 16: counter table depth. Power of two, ≥2. `IDX = log2(ENTRIES)`.
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a mispredict. Must be ≥1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `fetch_valid`  in  1  fetch presents an instruction this cycle.
- `fetch_opcode`  in  4  predecoded opcode; branch = 4'b0010.
- `fetch_pc`  in  BITWIDTH  word address of the fetched instruction.
- `fetch_target`  in  BITWIDTH  predecoded branch target.
- `pred_valid`  out  1  prediction valid, one cycle after the fetch.
- `pred_taken`  out  1  predicted direction.
- `pred_next_pc`  out  BITWIDTH  predicted next PC.
- `res_valid`  in  1  execute resolved a branch.
- `res_pc`  in  BITWIDTH  PC of the resolved branch.
- `res_taken`  in  1  actual outcome (evaluator `taken`).
- `res_pred_taken`  in  1  prediction carried down the pipe with the branch.
- `res_target`  in  BITWIDTH  actual taken target.
- `redirect_valid`  out  1  one-cycle pulse: fetch must load `redirect_pc`.
- `redirect_pc`  out  BITWIDTH  correct next PC.
- `flush`  out  1  squash younger in-flight instructions.
- `mispredict_count`  out  16  saturating mispredict counter.

## Operation
- The table has `ENTRIES` 2-bit counters. Index is `pc[IDX-1:0]`. Counter bit 1 set means predict taken.
- Lookup:
  - For a registered `fetch_valid` with `fetch_opcode == 4'b0010`: `pred_taken` = counter[1] and `pred_next_pc` = taken ? `fetch_target` : `fetch_pc + 1`.
  - For a non-branch opcode: `pred_taken = 0` and `pred_next_pc = fetch_pc + 1`.
  - `pred_valid` mirrors `fetch_valid`, delayed one cycle.
- Accepting a resolution: a resolution is accepted when `res_valid` is high and the FSM is in IDLE.
- Training on each accepted resolution:
  - Taken: counter += 1, saturating at 3.
  - Not taken: counter −= 1, saturating at 0.
- Mispredict on an accepted resolution means `res_taken != res_pred_taken`. Response:
  - `redirect_pc` = `res_taken` ? `res_target` : `res_pc + 1`.
  - `redirect_valid` pulses.
  - FSM goes to FLUSH.
  - `mispredict_count` increments, saturating at 16'hFFFF.
- FSM:
  - IDLE: an accepted mispredict moves to FLUSH and loads `flush_cnt = FLUSH_CYCLES − 1`.
  - FLUSH: `flush` = 1. `res_valid` is ignored: no training, no redirect, no count, because those are wrong-path branches. Return to IDLE when `flush_cnt == 0`, otherwise decrement.
- Simultaneous lookup and update to the same index: lookup returns the pre-update value (read-before-write).
- PC arithmetic is modulo 2^BITWIDTH. `fetch_pc + 1` wraps from all-ones to 0.
- Reset values:
  - All counters = 2'b01 (weakly not-taken).
  - FSM = IDLE.
  - `pred_valid`, `pred_taken`, `redirect_valid`, `flush` = 0.
  - `pred_next_pc`, `redirect_pc`, `mispredict_count` = 0.
- Reset asserted mid-flush returns the block immediately to the reset state. No redirect is issued after reset releases.

## Timing
- Lookup latency: 1 cycle, from `fetch_valid` at edge N to `pred_*` valid after edge N+1.
- Mispredict response:
  - Resolution at edge N.
  - `redirect_valid` high for exactly the cycle after N.
  - `flush` high for exactly `FLUSH_CYCLES` cycles starting the same cycle.
- Counter update is visible to a lookup at edge N+1 or later.
- Back-to-back resolutions are accepted every cycle while in IDLE.
- A correct prediction produces no redirect and no flush.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `branch_pkg` holds:
  - opcode constant `OP_BRANCH = 4'b0010`;
  - counter encodings `SNT = 0`, `WNT = 1`, `WT = 2`, `ST = 3`;
  - FSM state enum `{IDLE, FLUSH}`.
- One sub-module, `sat_counter2`: the 2-bit saturating increment/decrement function, instantiated through a generate over `ENTRIES`.
- The flush FSM and lookup registers live in the top module.

## Test plan
- Reset, then fetch branch at pc=5 with target=40 → cycle later `pred_valid=1`, `pred_taken=0`, `pred_next_pc=6`.
- Resolve pc=5 taken with `res_pred_taken=0` → `redirect_valid` 1 cycle, `redirect_pc=40`, `flush` 2 cycles, `mispredict_count=1`. Refetch pc=5 → `pred_taken=1`, `pred_next_pc=40`.
- During the 2-cycle flush, present `res_valid` mispredicts at pc=7 → no redirect, count unchanged, counter[7] still 01.
- Three taken resolutions at pc=3, then four not-taken → counter goes 01→10→11→11 (saturates), then 10→01→00→00 (saturates). Final prediction not-taken.
- Fetch pc=2 and resolve taken at pc=2 in the same cycle → prediction uses old 01 (not-taken). Next fetch of pc=2 predicts taken. Also: fetch pc=32'hFFFFFFFF non-branch → `pred_next_pc=0`.
- Assert `reset_n` low during flush cycle 1 → `flush`, `redirect_valid` drop immediately, counters return to 01, no redirect after release.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the fetch-side branch predictor: opcode, counter
// encodings and flush FSM states.
package branch_pkg;

  localparam logic [3:0] OP_BRANCH = 4'b0010;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bpu_state_e;

  function automatic logic predicts_taken(input logic [1:0] ctr);
    return (ctr >= WT);
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// One 2-bit saturating direction counter; trains toward the resolved outcome
// when enabled and resets to weakly not-taken.
module sat_counter2
  import branch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_i,
  input  logic       taken_i,
  output logic [1:0] count_o
);

  logic [1:0] count_q;
  logic [1:0] count_d;

  // Saturating step toward the resolved direction
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (taken_i) begin
        count_d = (count_q == ST) ? ST : (count_q + 2'd1);
      end else begin
        count_d = (count_q == SNT) ? SNT : (count_q - 2'd1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= WNT;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side branch direction predictor with resolution training, registered
// redirect on mispredict and a multi-cycle flush window.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int BITWIDTH     = 32,
  parameter int ENTRIES      = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                fetch_valid,
  input  logic [3:0]          fetch_opcode,
  input  logic [BITWIDTH-1:0] fetch_pc,
  input  logic [BITWIDTH-1:0] fetch_target,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [BITWIDTH-1:0] pred_next_pc,
  input  logic                res_valid,
  input  logic [BITWIDTH-1:0] res_pc,
  input  logic                res_taken,
  input  logic                res_pred_taken,
  input  logic [BITWIDTH-1:0] res_target,
  output logic                redirect_valid,
  output logic [BITWIDTH-1:0] redirect_pc,
  output logic                flush,
  output logic [15:0]         mispredict_count
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int CW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0]       FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [BITWIDTH-1:0] PC_ONE     = {{(BITWIDTH-1){1'b0}}, 1'b1};

  logic [1:0]         ctr_s [ENTRIES];
  logic [ENTRIES-1:0] upd_en_s;
  logic [IDX-1:0]     fetch_idx_s;
  logic [IDX-1:0]     res_idx_s;
  logic               accept_s;
  logic               mispredict_s;

  bpu_state_e         state_q, state_d;
  logic [CW-1:0]      flush_cnt_q, flush_cnt_d;
  logic               flush_q, flush_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [BITWIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [15:0]        mcount_q, mcount_d;
  logic               pred_valid_q, pred_valid_d;
  logic               pred_taken_q, pred_taken_d;
  logic [BITWIDTH-1:0] pred_next_pc_q, pred_next_pc_d;

  assign fetch_idx_s  = fetch_pc[IDX-1:0];
  assign res_idx_s    = res_pc[IDX-1:0];
  assign accept_s     = res_valid && (state_q == IDLE);
  assign mispredict_s = accept_s && (res_taken != res_pred_taken);

  // Counters are registered, so a same-cycle lookup sees the pre-update value.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    assign upd_en_s[g] = accept_s && (res_idx_s == IDX'(g));
    sat_counter2 u_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (upd_en_s[g]),
      .taken_i (res_taken),
      .count_o (ctr_s[g])
    );
  end

  // Lookup next-state; prediction fields hold when no fetch is presented
  always_comb begin
    pred_valid_d   = fetch_valid;
    pred_taken_d   = pred_taken_q;
    pred_next_pc_d = pred_next_pc_q;
    if (fetch_valid) begin
      if (fetch_opcode == OP_BRANCH) begin
        pred_taken_d   = predicts_taken(ctr_s[fetch_idx_s]);
        pred_next_pc_d = pred_taken_d ? fetch_target : (fetch_pc + PC_ONE);
      end else begin
        pred_taken_d   = 1'b0;
        pred_next_pc_d = fetch_pc + PC_ONE;
      end
    end else begin
      pred_taken_d   = pred_taken_q;
      pred_next_pc_d = pred_next_pc_q;
    end
  end

  // Flush FSM, redirect and mispredict counter next-state
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    redirect_valid_d = mispredict_s;
    redirect_pc_d    = redirect_pc_q;
    mcount_d         = mcount_q;
    case (state_q)
      IDLE: begin
        if (mispredict_s) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          state_d     = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == {CW{1'b0}}) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d     = IDLE;
        flush_cnt_d = {CW{1'b0}};
      end
    endcase
    if (mispredict_s) begin
      redirect_pc_d = res_taken ? res_target : (res_pc + PC_ONE);
      mcount_d      = (mcount_q == 16'hFFFF) ? mcount_q : (mcount_q + 16'd1);
    end else begin
      redirect_pc_d = redirect_pc_q;
      mcount_d      = mcount_q;
    end
    flush_d = (state_d == FLUSH);
  end

  // Registered state and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      flush_cnt_q      <= {CW{1'b0}};
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= {BITWIDTH{1'b0}};
      mcount_q         <= 16'd0;
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_next_pc_q   <= {BITWIDTH{1'b0}};
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mcount_q         <= mcount_d;
      pred_valid_q     <= pred_valid_d;
      pred_taken_q     <= pred_taken_d;
      pred_next_pc_q   <= pred_next_pc_d;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_next_pc     = pred_next_pc_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = flush_q;
  assign mispredict_count = mcount_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural predictor model.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [3:0]  fetch_opcode = 4'd0;
  logic [31:0] fetch_pc = 32'd0;
  logic [31:0] fetch_target = 32'd0;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = 32'd0;
  logic        res_taken = 1'b0;
  logic        res_pred_taken = 1'b0;
  logic [31:0] res_target = 32'd0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  // Reference model: counter values as integers, flush as cycles remaining
  int          m_ctr [16];
  bit          m_pv, m_pt, m_rv;
  logic [31:0] m_pnpc, m_rpc;
  int          m_cnt;
  int          m_flush_rem;

  branch_predict_unit #(.BITWIDTH(32), .ENTRIES(16), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_opcode(fetch_opcode),
    .fetch_pc(fetch_pc), .fetch_target(fetch_target),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_pred_taken(res_pred_taken), .res_target(res_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_pv = 0; m_pt = 0; m_rv = 0;
    m_pnpc = 32'd0; m_rpc = 32'd0;
    m_cnt = 0; m_flush_rem = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pred_valid"}, {31'd0, pred_valid}, {31'd0, m_pv});
    if (m_pv) begin
      check_eq({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, m_pt});
      check_eq({tag, ".pred_next_pc"}, pred_next_pc, m_pnpc);
    end
    check_eq({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, m_rv});
    if (m_rv) check_eq({tag, ".redirect_pc"}, redirect_pc, m_rpc);
    check_eq({tag, ".flush"}, {31'd0, flush}, {31'd0, (m_flush_rem > 0)});
    check_eq({tag, ".count"}, {16'd0, mispredict_count}, m_cnt);
  endtask

  // One clock: drive inputs at negedge, advance model, check after posedge
  task automatic step(input string tag,
                      input bit fv, input logic [3:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                      input bit rv, input logic [31:0] rpc, input bit rt, input bit rpt,
                      input logic [31:0] rtg);
    bit accept, mis;
    @(negedge clk);
    fetch_valid = fv; fetch_opcode = op; fetch_pc = pc; fetch_target = tgt;
    res_valid = rv; res_pc = rpc; res_taken = rt; res_pred_taken = rpt; res_target = rtg;
    m_pv = fv;
    if (fv) begin
      m_pt   = (op == 4'b0010) && (m_ctr[pc % 16] >= 2);
      m_pnpc = m_pt ? tgt : pc + 32'd1;
    end
    accept = rv && (m_flush_rem == 0);
    mis    = accept && (rt != rpt);
    if (m_flush_rem > 0) m_flush_rem--;
    if (accept) begin
      if (rt) m_ctr[rpc % 16] = (m_ctr[rpc % 16] == 3) ? 3 : m_ctr[rpc % 16] + 1;
      else    m_ctr[rpc % 16] = (m_ctr[rpc % 16] == 0) ? 0 : m_ctr[rpc % 16] - 1;
    end
    m_rv = mis;
    if (mis) begin
      m_rpc = rt ? rtg : rpc + 32'd1;
      if (m_cnt < 65535) m_cnt++;
      m_flush_rem = 2;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic fetch_br(input string tag, input logic [31:0] pc, input logic [31:0] tgt);
    step(tag, 1'b1, 4'b0010, pc, tgt, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input bit rt, input bit rpt,
                         input logic [31:0] tgt);
    step(tag, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, pc, rt, rpt, tgt);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    fetch_br("cold_pc5", 32'd5, 32'd40);
    check_eq("cold_pc5_taken", {31'd0, pred_taken}, 32'd0);
    check_eq("cold_pc5_npc", pred_next_pc, 32'd6);

    resolve("mis_pc5", 32'd5, 1'b1, 1'b0, 32'd40);
    check_eq("mis_pc5_redirect", redirect_pc, 32'd40);
    check_eq("mis_pc5_flush", {31'd0, flush}, 32'd1);
    check_eq("mis_pc5_count", {16'd0, mispredict_count}, 32'd1);

    // Wrong-path resolutions at pc 7 during the flush window, with a refetch of pc 5
    step("flush1", 1'b1, 4'b0010, 32'd5, 32'd40, 1'b1, 32'd7, 1'b1, 1'b0, 32'd99);
    check_eq("refetch_pc5_taken", {31'd0, pred_taken}, 32'd1);
    check_eq("refetch_pc5_npc", pred_next_pc, 32'd40);
    check_eq("flush1_noredirect", {31'd0, redirect_valid}, 32'd0);
    resolve("flush2", 32'd7, 1'b1, 1'b0, 32'd99);
    check_eq("flush2_count", {16'd0, mispredict_count}, 32'd1);
    idle("post_flush");
    check_eq("post_flush_low", {31'd0, flush}, 32'd0);
    fetch_br("pc7_untrained", 32'd7, 32'd99);
    check_eq("pc7_untrained_taken", {31'd0, pred_taken}, 32'd0);

    // Saturation walk at pc 3 with correct predictions (no flush)
    for (int i = 0; i < 3; i++) begin
      resolve("sat_up", 32'd3, 1'b1, 1'b1, 32'd60);
      fetch_br("sat_up_fetch", 32'd3, 32'd60);
    end
    check_eq("sat_up_final", {31'd0, pred_taken}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      resolve("sat_dn", 32'd3, 1'b0, 1'b0, 32'd60);
      fetch_br("sat_dn_fetch", 32'd3, 32'd60);
    end
    check_eq("sat_dn_final", {31'd0, pred_taken}, 32'd0);
    check_eq("sat_dn_npc", pred_next_pc, 32'd4);

    // Same-cycle lookup and update on pc 2 reads the old counter
    step("rbw", 1'b1, 4'b0010, 32'd2, 32'd100, 1'b1, 32'd2, 1'b1, 1'b0, 32'd100);
    check_eq("rbw_old_value", {31'd0, pred_taken}, 32'd0);
    fetch_br("rbw_next", 32'd2, 32'd100);
    check_eq("rbw_new_value", {31'd0, pred_taken}, 32'd1);
    step("wrap", 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_eq("wrap_npc", pred_next_pc, 32'd0);
    idle("settle");
    idle("settle");

    // Reset during the first flush cycle
    resolve("mis_before_rst", 32'd9, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_flush", {31'd0, flush}, 32'd0);
    check_eq("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    check_eq("rst_count", {16'd0, mispredict_count}, 32'd0);
    @(negedge clk);
    fetch_valid = 1'b0; res_valid = 1'b0;
    reset_n = 1'b1;
    idle("after_rst1");
    idle("after_rst2");
    idle("after_rst3");
    fetch_br("after_rst_pc5", 32'd5, 32'd40);
    check_eq("after_rst_pc5_taken", {31'd0, pred_taken}, 32'd0);

    // Randomized traffic over a small PC window to force index collisions
    for (int n = 0; n < 600; n++) begin
      logic [31:0] fpc, rpc;
      logic [3:0]  op;
      fpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 40);
      rpc = $urandom_range(0, 40);
      op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0010;
      step("rand", 1'($urandom_range(0, 1)), op, fpc, $urandom,
           ($urandom_range(0, 2) != 0), rpc, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
